reg_wr_arbiter: RTL and testbench
=================================

REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter: PW, default 3, meaning register address pointer is PW+1 bits and the register file holds 2**PW entries.
REQ-002 Parameter: DW, default 8, meaning write data width.
REQ-003 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous reset, active-high.
REQ-005 Port: req0_valid / req1_valid  input  1  requester 0 / 1 holds a pending register write.
REQ-006 Port: req0_addr / req1_addr  input  PW+1  target register address.
REQ-007 Port: req0_data / req1_data  input  DW  write data.
REQ-008 Port: req0_ready / req1_ready  output  1  request accepted this cycle when ready and valid are both high.
REQ-009 Port: stall  input  1  high blocks all acceptance.
REQ-010 Port: wr_en  output  1  write enable to the register file.
REQ-011 Port: wr_addr  output  PW+1  register file write address.
REQ-012 Port: dat_in  output  DW  register file write data.
REQ-013 Port: grant_id  output  1  requester whose write is currently on wr_en/wr_addr/dat_in.
REQ-014 Port: wr_count  output  8  number of writes issued, wraps 255->0.
REQ-015 Port: addr_err  output  1  sticky out-of-range flag (REQ-029).

Function
REQ-016 Shall be one clock domain (clk) with synchronous active-high reset on reset.
REQ-017 Shall keep 1-bit round-robin pointer rr; rr names the requester preferred on the next contention.
REQ-018 Shall make ready combinational: stall=1 -> both ready 0; only one valid -> that requester ready; both valid -> requester rr ready, other 0; none valid -> both 0.
REQ-019 Shall assert at most one ready per cycle.
REQ-020 On acceptance from requester k, rr shall become !k at the next edge; without acceptance rr shall hold.
REQ-021 Shall register accepted address/data: wr_en=1, wr_addr, dat_in, grant_id=k exactly one cycle after acceptance (latency 1).
REQ-022 Without acceptance in a cycle, wr_en shall be 0 the next cycle; wr_addr, dat_in and grant_id shall hold their last values.
REQ-023 Shall sustain back-to-back acceptance, one write per cycle, alternating under continuous contention.
REQ-024 Equal addresses from both requesters shall not be merged; each is written in grant order, later write wins.
REQ-025 stall shall not cancel a write already registered; that write still issues.
REQ-026 wr_count shall increment by 1 in the cycle each wr_en=1 is registered, counting writes actually issued.

Reset
REQ-027 On reset=1 at an edge: wr_en=0, wr_addr=0, dat_in=0, grant_id=0, rr=0, wr_count=0, addr_err=0.
REQ-028 While reset=1 both ready outputs shall be 0; an acceptance pending in the reset cycle shall be discarded (no write issues after reset).

Configuration
REQ-029 Macro REG_WR_RANGE_CHECK_EN defined: accepted request with addr[PW]=1 (beyond 2**PW entries) shall be consumed (ready handshake completes, rr advances) but shall produce wr_en=0, no wr_count increment, and addr_err set to 1 until reset.
REQ-030 Macro REG_WR_RANGE_CHECK_EN undefined: all addresses pass through unchanged and addr_err shall be tied 0.

Verification
REQ-031 Reset then req0_valid=1 addr=3 data=0xA5 alone -> req0_ready=1 same cycle; next cycle wr_en=1, wr_addr=3, dat_in=0xA5, grant_id=0, then wr_count=1.
REQ-032 Both valid continuously for 4 cycles after reset -> grants 0,1,0,1; wr_en high 4 consecutive cycles; wr_count=4.
REQ-033 Both valid, addr=5, data 0x11 (req0) / 0x22 (req1) -> writes 0x11 then 0x22 to addr 5.
REQ-034 Accept req1 then raise stall for 3 cycles with both valid -> req1 write issues next cycle; ready both 0 and wr_en 0 during remaining stall cycles.
REQ-035 reset asserted in the cycle req0 is accepted -> no wr_en next cycle, rr=0, wr_count=0.
REQ-036 With REG_WR_RANGE_CHECK_EN, req0 addr=9 -> ready=1, no wr_en, addr_err=1 sticky; without macro -> wr_en=1, wr_addr=9, addr_err=0.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
// Two-requester round-robin arbiter feeding a single register-file write port.
// Optional macro REG_WR_RANGE_CHECK_EN drops out-of-range writes and flags addr_err.
module reg_wr_arbiter #(
  parameter int unsigned PW = 3,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [PW:0]   req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [PW:0]   req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          stall,
  output logic          wr_en,
  output logic [PW:0]   wr_addr,
  output logic [DW-1:0] dat_in,
  output logic          grant_id,
  output logic [7:0]    wr_count,
  output logic          addr_err
);

  localparam int unsigned AW = PW + 1;

  logic          rr;
  logic          acc;
  logic          acc_id;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  logic          issue;

  // Combinational handshake; reset and stall both suppress acceptance.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset && !stall) begin
      if (req0_valid && req1_valid) begin
        req0_ready = ~rr;
        req1_ready = rr;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  always_comb begin
    acc      = req0_ready | req1_ready;
    acc_id   = req1_ready;
    acc_addr = req1_ready ? req1_addr : req0_addr;
    acc_data = req1_ready ? req1_data : req0_data;
  end

`ifdef REG_WR_RANGE_CHECK_EN
  logic addr_bad;
  logic err_q;

  assign addr_bad = acc & acc_addr[PW];
  assign issue    = acc & ~addr_bad;
  assign addr_err = err_q;

  // Out-of-range request is consumed but only raises the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (addr_bad) begin
      err_q <= 1'b1;
    end
  end
`else
  assign issue    = acc;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rr       <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      dat_in   <= '0;
      grant_id <= 1'b0;
      wr_count <= 8'd0;
    end else begin
      if (acc) begin
        rr <= ~acc_id;
      end
      wr_en <= issue;
      if (issue) begin
        wr_addr  <= acc_addr;
        dat_in   <= acc_data;
        grant_id <= acc_id;
        wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Randomized bench for reg_wr_arbiter against a cycle-level reference model.
module tb_reg_wr_arbiter;

  localparam int unsigned PW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = PW + 1;
`ifdef REG_WR_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          stall;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] dat_in;
  logic          grant_id;
  logic [7:0]    wr_count;
  logic          addr_err;

  reg_wr_arbiter #(.PW(PW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .grant_id(grant_id), .wr_count(wr_count), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the preferred requester, last issued write, and tallies.
  bit            known = 1'b0;
  int            pref = 0;
  bit            m_wen = 1'b0;
  int            m_addr = 0;
  int            m_data = 0;
  int            m_gid = 0;
  int            m_writes = 0;
  bit            m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit st,
                      input bit v0, input int a0, input int d0,
                      input bit v1, input int a1, input int d1);
    int  winner;
    bit  bad;
    @(negedge clk);
    reset = r; stall = st;
    req0_valid = v0; req0_addr = AW'(a0); req0_data = DW'(d0);
    req1_valid = v1; req1_addr = AW'(a1); req1_data = DW'(d1);
    #1;
    winner = -1;
    if (!r && !st) begin
      if (v0 && v1) winner = pref;
      else if (v0)  winner = 0;
      else if (v1)  winner = 1;
    end
    check("req0_ready", req0_ready, 32'(winner == 0));
    check("req1_ready", req1_ready, 32'(winner == 1));
    if (known) begin
      check("wr_en", wr_en, 32'(m_wen));
      check("wr_addr", wr_addr, 32'(m_addr));
      check("dat_in", dat_in, 32'(m_data));
      check("grant_id", grant_id, 32'(m_gid));
      check("addr_err", addr_err, 32'(m_err));
      if (!m_wen) check("wr_count", wr_count, 32'(m_writes % 256));
    end
    if (r) begin
      known = 1'b1; pref = 0; m_wen = 1'b0; m_addr = 0; m_data = 0;
      m_gid = 0; m_writes = 0; m_err = 1'b0;
    end else if (winner >= 0) begin
      int a;
      a = (winner == 0) ? (a0 % (1 << AW)) : (a1 % (1 << AW));
      bad = RANGE_EN && (a >= (1 << PW));
      pref = 1 - winner;
      m_wen = !bad;
      if (bad) m_err = 1'b1;
      else begin
        m_addr = a;
        m_data = ((winner == 0) ? d0 : d1) % (1 << DW);
        m_gid = winner;
        m_writes++;
      end
    end else begin
      m_wen = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("wr_count_reset", wr_count, 32'd0);

    // Single requester write with latency one.
    step(0, 0, 1, 3, 'hA5, 0, 0, 0);
    idle(1);
    check("single_wr_addr", wr_addr, 32'd3);
    check("single_dat_in", dat_in, 32'hA5);
    idle(1);
    check("single_count", wr_count, 32'd1);

    // Continuous contention alternates grants.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, i, 16 + i, 1, 8 + i, 32 + i);
    idle(2);
    check("contend_count", wr_count, 32'd4);

    // Same address from both: two writes in grant order.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 5, 'h11, 1, 5, 'h22);
    step(0, 0, 0, 0, 0, 1, 5, 'h22);
    check("same_addr_first", dat_in, 32'h11);
    idle(1);
    check("same_addr_second", dat_in, 32'h22);

    // Accept req1, then stall with both valid.
    step(0, 0, 0, 0, 0, 1, 2, 'h77);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 'h33, 1, 2, 'h44);
    idle(1);

    // Reset coincident with a valid request.
    step(1, 0, 1, 4, 'h99, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 6, 'h12, 1, 7, 'h34);
    idle(1);
    check("post_reset_gid", grant_id, 32'd0);

    // Out-of-range address behaviour.
    step(0, 0, 1, 9, 'h5A, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
